// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline widths, bubble encoding and fetch FSM states
package fetch_stage_pkg;
   localparam int WIDTH_DATA_LENGTH = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetch_state_t;
endpackage

// File: rtl/fetch_stage_fe_de_reg.sv
// fe_de_reg: enable/flush pipeline register carrying {pc, inst, valid}; flush wins over enable
module fe_de_reg #(
   parameter int W = fetch_stage_pkg::WIDTH_DATA_LENGTH,
   parameter logic [W-1:0] NOP = W'(fetch_stage_pkg::NOP_INST)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         flush,
   input  logic [W-1:0] d_pc,
   input  logic [W-1:0] d_inst,
   input  logic         d_valid,
   output logic [W-1:0] q_pc,
   output logic [W-1:0] q_inst,
   output logic         q_valid
);
   // flush turns the slot into a bubble but keeps the last pc for debug/trace
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         q_pc    <= '0;
         q_inst  <= NOP;
         q_valid <= 1'b0;
      end else if (flush) begin
         q_inst  <= NOP;
         q_valid <= 1'b0;
      end else if (en) begin
         q_pc    <= d_pc;
         q_inst  <= d_inst;
         q_valid <= d_valid;
      end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: pc register, single-outstanding imem handshake and FE/DE register
module fetch_stage #(
   parameter int WIDTH_DATA_LENGTH = fetch_stage_pkg::WIDTH_DATA_LENGTH,
   parameter logic [WIDTH_DATA_LENGTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH_DATA_LENGTH-1:0] NOP_INST = WIDTH_DATA_LENGTH'(fetch_stage_pkg::NOP_INST)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         PC_Fetch_EN,
   input  logic                         FE_DE_Reg_EN,
   input  logic                         Br_Taken,
   input  logic [WIDTH_DATA_LENGTH-1:0] Br_Target,
   output logic                         imem_req,
   output logic [WIDTH_DATA_LENGTH-1:0] imem_addr,
   input  logic                         imem_ack,
   input  logic [WIDTH_DATA_LENGTH-1:0] imem_rdata,
   output logic [WIDTH_DATA_LENGTH-1:0] FE_DE_PC,
   output logic [WIDTH_DATA_LENGTH-1:0] FE_DE_Inst,
   output logic                         FE_DE_Valid
);
   import fetch_stage_pkg::*;
   localparam int W = WIDTH_DATA_LENGTH;
   localparam logic [W-1:0] ALIGN_MASK = ~W'(3);
   fetch_state_t state;
   logic [W-1:0] pc;
   logic [W-1:0] pc_req;
   logic [W-1:0] hold_buf;
   logic         deliver;
   logic         flush;
   logic [W-1:0] deliver_inst;
   // a request is only issued from REQ, never during a redirect or while in reset
   always_comb begin
      imem_req     = (state == REQ) && PC_Fetch_EN && !Br_Taken && !rst;
      imem_addr    = pc;
      deliver      = !Br_Taken && FE_DE_Reg_EN &&
                     ((state == WAIT && imem_ack) || state == HOLD);
      deliver_inst = (state == HOLD) ? hold_buf : imem_rdata;
      flush        = Br_Taken || (FE_DE_Reg_EN && !deliver);
   end
   // fetch FSM: redirect overrides every other event; an ack in DROP retires the
   // squashed request even when a further redirect lands in that cycle
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= REQ;
         pc       <= RESET_PC;
         pc_req   <= '0;
         hold_buf <= NOP_INST;
      end else if (Br_Taken) begin
         pc    <= Br_Target & ALIGN_MASK;
         state <= ((state == WAIT || state == DROP) && !imem_ack) ? DROP : REQ;
      end else
         case (state)
            REQ:
               if (imem_req) begin
                  pc_req <= pc;
                  pc     <= pc + W'(4);
                  state  <= WAIT;
               end
            WAIT:
               if (imem_ack) begin
                  if (!FE_DE_Reg_EN) hold_buf <= imem_rdata;
                  state <= FE_DE_Reg_EN ? REQ : HOLD;
               end
            HOLD:
               if (FE_DE_Reg_EN) state <= REQ;
            DROP:
               if (imem_ack) state <= REQ;
         endcase
   fe_de_reg #(.W(W), .NOP(NOP_INST)) u_fe_de (
      .clk     (clk),
      .rst     (rst),
      .en      (deliver),
      .flush   (flush),
      .d_pc    (pc_req),
      .d_inst  (deliver_inst),
      .d_valid (1'b1),
      .q_pc    (FE_DE_PC),
      .q_inst  (FE_DE_Inst),
      .q_valid (FE_DE_Valid)
   );
endmodule
